// File: rtl/mul_pkg.sv
// Shared widths, FSM states and the result record for the multiplier collector.
// Optional overflow flag field is present when MUL_ACC_OVF_EN is defined.
package mul_pkg;
    localparam int PROD_W      = 128;
    localparam int GUARD_W     = 8;
    localparam int ACC_W       = PROD_W + GUARD_W;
    localparam int MUL_LAT_DEF = 5;
    localparam int BEATS_W     = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_t;

    typedef struct packed {
        logic [ACC_W-1:0]   sum;
        logic [BEATS_W-1:0] beats;
`ifdef MUL_ACC_OVF_EN
        logic               ovf;
`endif
    } result_t;

    localparam int RES_W = $bits(result_t);
endpackage

// File: rtl/res_fifo.sv
// Generic synchronous FIFO with full/empty flags and occupancy count.
// A push while full is taken only when a pop happens in the same cycle.
module res_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_do_push & ~w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop & ~w_do_push) r_count <= r_count - 1'b1;
        end
    end
endmodule

// File: rtl/mul_acc_collector.sv
// Collects framed multiplier products into wide sums, behind a credit-throttled result FIFO.
// Define MUL_ACC_OVF_EN to add the per-frame sticky carry-out flag out_ovf.
module mul_acc_collector
    import mul_pkg::*;
#(
    parameter int MUL_LAT   = MUL_LAT_DEF,
    parameter int OUT_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               issue,
    input  logic               issue_last,
    output logic               issue_ready,
    input  logic [PROD_W-1:0]  prod,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic [BEATS_W-1:0] out_beats
`ifdef MUL_ACC_OVF_EN
    ,
    output logic               out_ovf
`endif
);
    localparam int CRED_W = $clog2(OUT_DEPTH+1);

    logic [MUL_LAT-1:0] r_vld_pipe;
    logic [MUL_LAT-1:0] r_last_pipe;
    logic [CRED_W-1:0]  r_outstanding;
    acc_state_t         r_state;
    acc_state_t         w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [BEATS_W-1:0] r_beats;
    logic [ACC_W-1:0]   w_base;
    logic [ACC_W-1:0]   w_sum_nxt;
    logic [BEATS_W-1:0] w_beats_nxt;
    logic               w_acc_beat;
    logic               w_d_vld;
    logic               w_d_last;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_full;
    logic [CRED_W-1:0]  w_count;
    logic               w_unused;
    result_t            w_push_rec;
    result_t            w_head;
`ifdef MUL_ACC_OVF_EN
    logic               r_ovf;
    logic               w_ovf_nxt;
    logic [ACC_W:0]     w_add;
`endif

    assign issue_ready = (r_outstanding < CRED_W'(OUT_DEPTH));
    assign w_acc_beat  = issue & issue_ready;
    assign w_d_vld     = r_vld_pipe[MUL_LAT-1];
    assign w_d_last    = r_last_pipe[MUL_LAT-1];
    assign w_pop       = out_valid & out_ready;

    // Valid/last ride alongside the operands so the tap lines up with prod.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
        end else begin
            r_vld_pipe[0]  <= w_acc_beat;
            r_last_pipe[0] <= w_acc_beat & issue_last;
            for (int k = 1; k < MUL_LAT; k++) begin
                r_vld_pipe[k]  <= r_vld_pipe[k-1];
                r_last_pipe[k] <= r_last_pipe[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_d_vld && !w_d_last) w_state_nxt = ST_ACCUM;
            ST_ACCUM: if (w_d_vld && w_d_last)  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // IDLE starts a fresh frame from zero, so the same adder serves both states.
    always_comb begin
        w_base      = (r_state == ST_ACCUM) ? r_acc : '0;
        w_beats_nxt = (r_state == ST_ACCUM) ? r_beats + 1'b1 : BEATS_W'(1);
`ifdef MUL_ACC_OVF_EN
        w_add       = {1'b0, w_base} + (ACC_W+1)'(prod);
        w_sum_nxt   = w_add[ACC_W-1:0];
        w_ovf_nxt   = ((r_state == ST_ACCUM) & r_ovf) | w_add[ACC_W];
`else
        w_sum_nxt   = w_base + ACC_W'(prod);
`endif
        w_push           = w_d_vld & w_d_last;
        w_push_rec       = '0;
        w_push_rec.sum   = w_sum_nxt;
        w_push_rec.beats = w_beats_nxt;
`ifdef MUL_ACC_OVF_EN
        w_push_rec.ovf   = w_ovf_nxt;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc   <= '0;
            r_beats <= '0;
`ifdef MUL_ACC_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_d_vld) begin
            r_acc   <= w_sum_nxt;
            r_beats <= w_beats_nxt;
`ifdef MUL_ACC_OVF_EN
            r_ovf   <= w_ovf_nxt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_outstanding <= '0;
        end else begin
            case ({w_acc_beat & issue_last, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    res_fifo #(
        .WIDTH (RES_W),
        .DEPTH (OUT_DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_rec),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_unused  = ^{w_full, w_count};
    assign out_valid = ~w_empty;
    assign out_sum   = w_head.sum;
    assign out_beats = w_head.beats;
`ifdef MUL_ACC_OVF_EN
    assign out_ovf   = w_head.ovf;
`endif
endmodule
